// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Central stall/flush controller for the 5-stage pipeline. It handles
// three events:
//   - taken branches: squash the instructions in IF/ID and ID/EX,
//   - load-use hazards: stall fetch/decode for one cycle and insert a bubble,
//   - multi-cycle multiply/divide: freeze the front end and hold ID/EX
//     until the operation finishes.
// It also keeps saturating 8-bit counts of the stall cycles it inserts.
//
// Parameters
//   MD_LATENCY     EX-stage cycles a multiply/divide occupies (2..15)
//
// Ports
//   clk            pipeline clock, rising-edge active
//   rst            asynchronous active-high reset
//   IDEX_MemRead   instruction in EX is a load
//   IDEX_RT        destination register of the instruction in EX
//   IFID_RS        first source register of the instruction in ID
//   IFID_RT        second source register of the instruction in ID
//   IFID_UsesRT    instruction in ID actually reads IFID_RT
//   Branch_taken   branch resolved taken in EX this cycle
//   MD_start       multiply/divide entered EX this cycle
//   PC_Write       PC may update
//   IFID_Write     IF/ID register may load
//   IFID_FLUSH     IF/ID register loads a bubble
//   IDEX_FLUSH     ID/EX register loads all-zero controls
//   IDEX_Hold      ID/EX register keeps its contents
//   busy           multi-cycle wait in progress
//   load_stall_cnt load-use stall cycles inserted (saturating)
//   md_stall_cnt   multiply/divide wait cycles inserted (saturating)
// ---------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int MD_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IDEX_MemRead,
  input  logic [3:0] IDEX_RT,
  input  logic [3:0] IFID_RS,
  input  logic [3:0] IFID_RT,
  input  logic       IFID_UsesRT,
  input  logic       Branch_taken,
  input  logic       MD_start,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IFID_FLUSH,
  output logic       IDEX_FLUSH,
  output logic       IDEX_Hold,
  output logic       busy,
  output logic [7:0] load_stall_cnt,
  output logic [7:0] md_stall_cnt
);

  typedef enum logic {
    IDLE,
    MD_WAIT
  } state_t;

  // The wait lasts MD_LATENCY-1 cycles: the MD_start cycle itself is the
  // first EX cycle of the operation and runs with normal outputs.
  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] md_cnt;
  logic [3:0] md_cnt_next;
  logic       load_use;
  logic       load_inc;
  logic       md_inc;

  // Register 0 is an ordinary register here, so a match on it still stalls.
  assign load_use = IDEX_MemRead &&
                    ((IDEX_RT == IFID_RS) || (IFID_UsesRT && (IDEX_RT == IFID_RT)));

  // Next-state and output decode. In IDLE the priority is branch, then
  // multiply/divide start, then load-use. In MD_WAIT every other event is
  // ignored; the front end is frozen and ID/EX is held rather than flushed,
  // so IDEX_FLUSH and IDEX_Hold can never both be high.
  always_comb begin
    state_next  = state;
    md_cnt_next = md_cnt;
    load_inc    = 1'b0;
    md_inc      = 1'b0;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    IDEX_Hold   = 1'b0;
    busy        = 1'b0;

    case (state)
      IDLE: begin
        if (Branch_taken) begin
          IFID_FLUSH = 1'b1;
          IDEX_FLUSH = 1'b1;
        end else if (MD_start) begin
          state_next  = MD_WAIT;
          md_cnt_next = MD_LOAD;
        end else if (load_use) begin
          PC_Write   = 1'b0;
          IFID_Write = 1'b0;
          IDEX_FLUSH = 1'b1;
          load_inc   = 1'b1;
        end
      end

      MD_WAIT: begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Hold   = 1'b1;
        busy        = 1'b1;
        md_inc      = 1'b1;
        md_cnt_next = md_cnt - 4'd1;
        // md_cnt==1 is the last wait cycle; <= also guards against a
        // zero count ever trapping the machine in MD_WAIT.
        if (md_cnt <= 4'd1) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next  = IDLE;
        md_cnt_next = 4'd0;
      end
    endcase
  end

  // State and down-counter registers; reset aborts any wait in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  // Saturating stall counters: they stop at 255 instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_stall_cnt <= 8'd0;
      md_stall_cnt   <= 8'd0;
    end else begin
      if (load_inc && (load_stall_cnt != 8'hFF)) begin
        load_stall_cnt <= load_stall_cnt + 8'd1;
      end
      if (md_inc && (md_stall_cnt != 8'hFF)) begin
        md_stall_cnt <= md_stall_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Directed-vector bench for hazard_control_unit (MD_LATENCY = 4). Each
// vector is driven just after a rising edge and its expected outputs are
// queued; a monitor pops one expectation per falling edge and compares.
// Control outputs are packed as
//   {PC_Write, IFID_Write, IFID_FLUSH, IDEX_FLUSH, IDEX_Hold, busy}.
// Counter expectations are the values visible during the cycle, i.e.
// before that cycle's increment lands on the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] FLUSH = 6'b111100;
  localparam logic [5:0] WAIT  = 6'b000011;

  typedef struct {
    string      name;
    logic [5:0] ctl;
    logic [7:0] lcnt;
    logic [7:0] mcnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       IDEX_MemRead;
  logic [3:0] IDEX_RT;
  logic [3:0] IFID_RS;
  logic [3:0] IFID_RT;
  logic       IFID_UsesRT;
  logic       Branch_taken;
  logic       MD_start;
  logic       PC_Write;
  logic       IFID_Write;
  logic       IFID_FLUSH;
  logic       IDEX_FLUSH;
  logic       IDEX_Hold;
  logic       busy;
  logic [7:0] load_stall_cnt;
  logic [7:0] md_stall_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_control_unit #(.MD_LATENCY(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .IDEX_MemRead   (IDEX_MemRead),
    .IDEX_RT        (IDEX_RT),
    .IFID_RS        (IFID_RS),
    .IFID_RT        (IFID_RT),
    .IFID_UsesRT    (IFID_UsesRT),
    .Branch_taken   (Branch_taken),
    .MD_start       (MD_start),
    .PC_Write       (PC_Write),
    .IFID_Write     (IFID_Write),
    .IFID_FLUSH     (IFID_FLUSH),
    .IDEX_FLUSH     (IDEX_FLUSH),
    .IDEX_Hold      (IDEX_Hold),
    .busy           (busy),
    .load_stall_cnt (load_stall_cnt),
    .md_stall_cnt   (md_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic applyStimulus(input logic r, input logic mr, input logic [3:0] xrt,
                               input logic [3:0] rs, input logic [3:0] rt,
                               input logic ur, input logic br, input logic md,
                               input string name, input logic [5:0] ctl,
                               input logic [7:0] lc, input logic [7:0] mc);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    IDEX_MemRead = mr;
    IDEX_RT      = xrt;
    IFID_RS      = rs;
    IFID_RT      = rt;
    IFID_UsesRT  = ur;
    Branch_taken = br;
    MD_start     = md;
    e.name = name;
    e.ctl  = ctl;
    e.lcnt = lc;
    e.mcnt = mc;
    exp_q.push_back(e);
  endtask

  task automatic idleCycle(input string name, input logic [7:0] lc, input logic [7:0] mc);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, name, NORM, lc, mc);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [5:0] ctl;
    ctl = {PC_Write, IFID_Write, IFID_FLUSH, IDEX_FLUSH, IDEX_Hold, busy};
    checks++;
    if (ctl !== e.ctl || load_stall_cnt !== e.lcnt || md_stall_cnt !== e.mcnt) begin
      errors++;
      $display("[TB] FAIL %s: got ctl=%b load=%0d md=%0d, expected ctl=%b load=%0d md=%0d",
               e.name, ctl, load_stall_cnt, md_stall_cnt, e.ctl, e.lcnt, e.mcnt);
    end
  endtask

  // Monitor: one expectation is consumed per cycle, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    IDEX_MemRead = 1'b0;
    IDEX_RT      = 4'd0;
    IFID_RS      = 4'd0;
    IFID_RT      = 4'd0;
    IFID_UsesRT  = 1'b0;
    Branch_taken = 1'b0;
    MD_start     = 1'b0;

    // Reset state and release
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "reset", NORM, 8'd0, 8'd0);
    idleCycle("after_reset", 8'd0, 8'd0);

    // Load-use on RS
    applyStimulus(1'b0, 1'b1, 4'd5, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, "load_use_rs", STALL, 8'd0, 8'd0);
    idleCycle("after_load_use_rs", 8'd1, 8'd0);

    // RT match ignored when RT is not read, then honoured when it is
    applyStimulus(1'b0, 1'b1, 4'd7, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0, "rt_unused", NORM, 8'd1, 8'd0);
    applyStimulus(1'b0, 1'b1, 4'd7, 4'd3, 4'd7, 1'b1, 1'b0, 1'b0, "rt_used", STALL, 8'd1, 8'd0);
    // Match without MemRead is not a hazard
    applyStimulus(1'b0, 1'b0, 4'd9, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0, "no_memread", NORM, 8'd2, 8'd0);
    // Register 0 still counts
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, "reg0_hazard", STALL, 8'd2, 8'd0);
    idleCycle("after_reg0", 8'd3, 8'd0);

    // Branch beats load-use; branch alone flushes exactly one cycle
    applyStimulus(1'b0, 1'b1, 4'd5, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, "branch_over_load", FLUSH, 8'd3, 8'd0);
    idleCycle("after_branch_load", 8'd3, 8'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "branch_alone", FLUSH, 8'd3, 8'd0);
    // Branch beats MD_start: no wait follows
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, "branch_over_md", FLUSH, 8'd3, 8'd0);
    idleCycle("after_branch_md", 8'd3, 8'd0);

    // MD_start beats load-use; three wait cycles ignore branch and hazard
    applyStimulus(1'b0, 1'b1, 4'd5, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1, "md_start", NORM, 8'd3, 8'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "md_wait1", WAIT, 8'd3, 8'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, "md_wait2_branch", WAIT, 8'd3, 8'd1);
    applyStimulus(1'b0, 1'b1, 4'd6, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, "md_wait3_load", WAIT, 8'd3, 8'd2);
    idleCycle("md_done", 8'd3, 8'd3);
    idleCycle("md_done2", 8'd3, 8'd3);

    // Reset in the second wait cycle aborts the wait immediately
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "md2_start", NORM, 8'd3, 8'd3);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "md2_wait1", WAIT, 8'd3, 8'd3);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "reset_mid_wait", NORM, 8'd0, 8'd0);
    idleCycle("after_abort", 8'd0, 8'd0);
    idleCycle("after_abort2", 8'd0, 8'd0);

    // Saturation of the load-use counter
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b1, 4'd2, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, "load_sat", STALL,
                    (i > 255) ? 8'd255 : 8'(i), 8'd0);
    end
    idleCycle("load_sat_hold", 8'd255, 8'd0);

    // Drain the scoreboard, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter: MD_LATENCY, default 4, number of EX-stage cycles a multiply/divide occupies; legal range 2..15.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 IDEX_MemRead  input  1  instruction currently in ID/EX (EX stage) is a load.
REQ-005 IDEX_RT  input  4  destination register of the instruction in EX.
REQ-006 IFID_RS  input  4  first source register of the instruction in ID.
REQ-007 IFID_RT  input  4  second source register of the instruction in ID.
REQ-008 IFID_UsesRT  input  1  the instruction in ID reads IFID_RT.
REQ-009 Branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-010 MD_start  input  1  multiply/divide entered EX this cycle.
REQ-011 PC_Write  output  1  PC may update.
REQ-012 IFID_Write  output  1  IF/ID register may load.
REQ-013 IFID_FLUSH  output  1  IF/ID register loads a bubble.
REQ-014 IDEX_FLUSH  output  1  ID/EX register loads all-zero controls (drives the IDEX_FLUSH input of the ID/EX buffer).
REQ-015 IDEX_Hold  output  1  ID/EX register keeps its contents.
REQ-016 busy  output  1  multi-cycle wait in progress.
REQ-017 load_stall_cnt  output  8  number of load-use stall cycles inserted.
REQ-018 md_stall_cnt  output  8  number of multiply/divide wait cycles inserted.

Function
REQ-019 State machine SHALL have two states: IDLE and MD_WAIT, plus a 4-bit down-counter md_cnt.
REQ-020 Outputs SHALL be combinational from current state and inputs; state, md_cnt and stall counters SHALL be registered.
REQ-021 Load-use hazard SHALL be: IDEX_MemRead=1 and (IDEX_RT=IFID_RS or (IFID_UsesRT=1 and IDEX_RT=IFID_RT)).
REQ-022 Per-cycle priority in IDLE SHALL be Branch_taken > MD_start > load-use hazard > normal.
REQ-023 IDLE normal: PC_Write=1, IFID_Write=1, IFID_FLUSH=0, IDEX_FLUSH=0, IDEX_Hold=0, busy=0.
REQ-024 IDLE with Branch_taken: PC_Write=1, IFID_Write=1, IFID_FLUSH=1, IDEX_FLUSH=1, IDEX_Hold=0; state stays IDLE; exactly one flush cycle per Branch_taken cycle.
REQ-025 IDLE with load-use hazard (no higher priority event): PC_Write=0, IFID_Write=0, IDEX_FLUSH=1, IFID_FLUSH=0, IDEX_Hold=0; state stays IDLE; load_stall_cnt increments by 1.
REQ-026 IDLE with MD_start: outputs as normal this cycle; next state MD_WAIT, md_cnt loaded with MD_LATENCY-1.
REQ-027 MD_WAIT: PC_Write=0, IFID_Write=0, IDEX_Hold=1, IDEX_FLUSH=0, IFID_FLUSH=0, busy=1; md_cnt decrements each cycle; md_stall_cnt increments each cycle.
REQ-028 MD_WAIT with md_cnt=1 SHALL transition to IDLE on next edge; total wait cycles = MD_LATENCY-1.
REQ-029 Branch_taken, MD_start and load-use hazard SHALL be ignored in MD_WAIT (no flush, no counter effect except md_stall_cnt).
REQ-030 load_stall_cnt and md_stall_cnt SHALL saturate at 255 and never wrap.
REQ-031 Outputs SHALL never assert IDEX_FLUSH and IDEX_Hold simultaneously.
REQ-032 Register 0 is not special: a match on register 0 is a hazard.

Reset
REQ-033 rst=1 SHALL immediately, without a clock edge, force state=IDLE, md_cnt=0, load_stall_cnt=0, md_stall_cnt=0.
REQ-034 During and after reset, outputs SHALL be the IDLE-normal values of REQ-023 unless inputs cause a hazard.
REQ-035 Reset asserted mid-MD_WAIT SHALL abort the wait; first cycle after deassertion is IDLE.

Verification
REQ-036 IDEX_MemRead=1, IDEX_RT=5, IFID_RS=5 for one cycle -> PC_Write=0, IFID_Write=0, IDEX_FLUSH=1, load_stall_cnt 0->1.
REQ-037 IDEX_MemRead=1, IDEX_RT=7, IFID_RT=7, IFID_UsesRT=0, IFID_RS=3 -> no stall, all IDLE-normal outputs.
REQ-038 Branch_taken=1 together with load-use hazard -> IFID_FLUSH=1, IDEX_FLUSH=1, PC_Write=1, load_stall_cnt unchanged.
REQ-039 MD_start pulse with MD_LATENCY=4 -> busy=1, IDEX_Hold=1, PC_Write=0 for exactly 3 cycles, md_stall_cnt=3, then IDLE.
REQ-040 rst pulsed during cycle 2 of MD_WAIT -> busy=0 asynchronously, counters=0, next cycle IDLE-normal.
REQ-041 300 consecutive load-use hazard cycles -> load_stall_cnt holds at 255.
